// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the vending machine datapath stages.
// Coin denominations are indexed in ascending value order.
package vending_machine_pkg;

  localparam int unsigned kNumCoins   = 3;
  localparam int unsigned kTotalBits  = 31;
  localparam int unsigned kWaitCycles = 100;
  localparam int unsigned kWaitBits   = 32;

  typedef logic [kTotalBits-1:0] money_t;
  typedef logic [kNumCoins-1:0]  coin_vec_t;
  typedef logic [kWaitBits-1:0]  wait_t;

  localparam money_t kCoinValue0 = money_t'(100);
  localparam money_t kCoinValue1 = money_t'(500);
  localparam money_t kCoinValue2 = money_t'(1000);

  localparam wait_t kWaitReload = wait_t'(kWaitCycles);

  typedef enum logic {
    IDLE   = 1'b0,
    RETURN = 1'b1
  } state_e;

  // Monetary value of a one-hot coin vector; zero when no coin is set.
  function automatic money_t coin_vec_value(input coin_vec_t coins);
    money_t v;
    v = '0;
    case (coins)
      3'b001:  v = kCoinValue0;
      3'b010:  v = kCoinValue1;
      3'b100:  v = kCoinValue2;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Picks the largest denomination that still fits in the remaining balance.
// Purely combinational; fit is low when the balance is below the smallest coin.
module coin_select
  import vending_machine_pkg::*;
(
  input  money_t    remaining,
  output coin_vec_t coin,
  output logic      fit
);

  always_comb begin
    coin = '0;
    fit  = 1'b0;
    if (remaining >= kCoinValue2) begin
      coin = 3'b100;
      fit  = 1'b1;
    end else if (remaining >= kCoinValue1) begin
      coin = 3'b010;
      fit  = 1'b1;
    end else if (remaining >= kCoinValue0) begin
      coin = 3'b001;
      fit  = 1'b1;
    end
  end

endmodule

// File: rtl/change_return_sequencer.sv
// Inactivity timer and greedy change-return sequencer, one coin per cycle.
// Define VM_TIMEOUT_RETURN_EN to let an expired inactivity timer start a return.
module change_return_sequencer
  import vending_machine_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [kTotalBits-1:0] i_current_total,
  input  logic                  i_activity,
  input  logic                  i_trigger_return,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic [kWaitBits-1:0]  o_wait_time,
  output logic                  o_busy,
  output logic                  o_residue
);

  state_e    state, state_next;
  money_t    remaining, remaining_next;
  coin_vec_t coin_next;
  coin_vec_t sel_coin;
  logic      sel_fit;
  logic      busy_next, residue_next;
  wait_t     wait_next;
  logic      start_c;
  logic      timeout_c;

  coin_select u_coin_select (
    .remaining (remaining),
    .coin      (sel_coin),
    .fit       (sel_fit)
  );

`ifdef VM_TIMEOUT_RETURN_EN
  assign timeout_c = (o_wait_time == '0) && (i_current_total != '0);
`else
  logic unused_activity;
  assign unused_activity = i_activity;
  assign timeout_c = 1'b0;
`endif

  assign start_c = i_trigger_return || timeout_c;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      o_return_coin <= '0;
      o_wait_time   <= kWaitReload;
      o_busy        <= 1'b0;
      o_residue     <= 1'b0;
    end else begin
      state         <= state_next;
      remaining     <= remaining_next;
      o_return_coin <= coin_next;
      o_wait_time   <= wait_next;
      o_busy        <= busy_next;
      o_residue     <= residue_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_c) state_next = RETURN;
      RETURN:  if (!sel_fit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the datapath and outputs.
  always_comb begin
    remaining_next = remaining;
    coin_next      = '0;
    busy_next      = 1'b0;
    residue_next   = o_residue;
    wait_next      = o_wait_time;
    case (state)
      IDLE: begin
        if (start_c) begin
          remaining_next = i_current_total;
          residue_next   = 1'b0;
          wait_next      = kWaitReload;
        end else begin
`ifdef VM_TIMEOUT_RETURN_EN
          if (i_current_total == '0 || i_activity) begin
            wait_next = kWaitReload;
          end else if (o_wait_time != '0) begin
            wait_next = o_wait_time - wait_t'(1);
          end
`else
          wait_next = kWaitReload;
`endif
        end
      end
      RETURN: begin
        wait_next = kWaitReload;
        if (sel_fit) begin
          coin_next      = sel_coin;
          busy_next      = 1'b1;
          remaining_next = remaining - coin_vec_value(sel_coin);
        end else begin
          residue_next = (remaining != '0);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_change_return_sequencer.sv
// Directed plus randomized bench for change_return_sequencer with a greedy change model.
// Timeout scenarios are exercised when VM_TIMEOUT_RETURN_EN is defined.
module tb_change_return_sequencer;
  import vending_machine_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [kTotalBits-1:0] total;
  logic                  activity;
  logic                  trig;
  logic [kNumCoins-1:0]  coin;
  logic [31:0]           wait_time;
  logic                  busy;
  logic                  residue;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_wait;
  logic exp_residue;

  always #5 clk = ~clk;

  change_return_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .i_current_total  (total),
    .i_activity       (activity),
    .i_trigger_return (trig),
    .o_return_coin    (coin),
    .o_wait_time      (wait_time),
    .o_busy           (busy),
    .o_residue        (residue)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_coin"}, 32'(coin), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wait"}, wait_time, 32'(exp_wait));
    check({tag, "_residue"}, 32'(residue), 32'(exp_residue));
  endtask

  // One idle cycle; the model follows the inactivity-timer rules directly.
  task automatic idle_cycle(input int unsigned t, input logic act);
    total    = kTotalBits'(t);
    activity = act;
    trig     = 1'b0;
    step();
`ifdef VM_TIMEOUT_RETURN_EN
    if (t == 0 || act) exp_wait = 100;
    else if (exp_wait > 0) exp_wait = exp_wait - 1;
`else
    exp_wait = 100;
`endif
    check_idle("idle");
  endtask

  // Expected coins via greedy division over denominations, largest first.
  task automatic check_sequence(input int unsigned t, input logic retrig, input string tag);
    logic [2:0]  q[$];
    int unsigned rem;
    int unsigned denom[3] = '{1000, 500, 100};
    logic [2:0]  onehot[3] = '{3'b100, 3'b010, 3'b001};
    rem = t;
    for (int k = 0; k < 3; k++) begin
      for (int unsigned n = 0; n < rem / denom[k]; n++) q.push_back(onehot[k]);
      rem = rem % denom[k];
    end
    foreach (q[i]) begin
      total    = kTotalBits'($urandom_range(0, 5000));
      activity = 1'($urandom);
      trig     = retrig;
      step();
      check({tag, "_coin"}, 32'(coin), 32'(q[i]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_wait_ret"}, wait_time, 32'd100);
    end
    trig     = 1'b0;
    activity = 1'b0;
    step();
    exp_wait    = 100;
    exp_residue = (rem != 0);
    check({tag, "_exit_coin"}, 32'(coin), 32'd0);
    check({tag, "_exit_busy"}, 32'(busy), 32'd0);
    check({tag, "_exit_residue"}, 32'(residue), 32'(exp_residue));
  endtask

  task automatic run_return(input int unsigned t, input logic act, input logic retrig, input string tag);
    total    = kTotalBits'(t);
    activity = act;
    trig     = 1'b1;
    step();
    trig     = 1'b0;
    activity = 1'b0;
    check({tag, "_entry_coin"}, 32'(coin), 32'd0);
    check({tag, "_entry_busy"}, 32'(busy), 32'd0);
    check({tag, "_entry_wait"}, wait_time, 32'd100);
    check({tag, "_entry_residue"}, 32'(residue), 32'd0);
    check_sequence(t, retrig, tag);
  endtask

  initial begin
    reset    = 1'b1;
    total    = '0;
    activity = 1'b0;
    trig     = 1'b0;
    step();
    step();
    exp_wait    = 100;
    exp_residue = 1'b0;
    check_idle("reset");
    reset = 1'b0;

    // Zero balance keeps the timer parked.
    for (int i = 0; i < 10; i++) idle_cycle(0, 1'b0);

    run_return(1600, 1'b0, 1'b0, "r1600");
    run_return(2050, 1'b0, 1'b0, "r2050");
    run_return(300, 1'b1, 1'b1, "r300_retrig");
    run_return(0, 1'b0, 1'b0, "r0");

    // Reset while the second coin of a 1600 return is visible.
    total = kTotalBits'(1600);
    trig  = 1'b1;
    step();
    trig = 1'b0;
    step();
    check("rst_c1", 32'(coin), 32'b100);
    step();
    check("rst_c2", 32'(coin), 32'b010);
    reset = 1'b1;
    step();
    reset       = 1'b0;
    exp_wait    = 100;
    exp_residue = 1'b0;
    check_idle("rst_abort");
    for (int i = 0; i < 3; i++) idle_cycle(1600, 1'b0);

`ifdef VM_TIMEOUT_RETURN_EN
    idle_cycle(500, 1'b1);
    for (int i = 0; i < 200 && exp_wait != 40; i++) idle_cycle(500, 1'b0);
    check("to_at40", wait_time, 32'd40);
    idle_cycle(500, 1'b1);
    check("to_reload", wait_time, 32'd100);
    for (int i = 0; i < 200 && exp_wait != 0; i++) idle_cycle(500, 1'b0);
    check("to_zero", wait_time, 32'd0);
    total = kTotalBits'(500);
    step();
    check("to_entry_coin", 32'(coin), 32'd0);
    check("to_entry_wait", wait_time, 32'd100);
    check_sequence(500, 1'b0, "to500");
`else
    for (int i = 0; i < 120; i++) idle_cycle(500, 1'b0);
`endif

    // Randomized idle stretches followed by returns of random balances.
    for (int it = 0; it < 30; it++) begin
      int unsigned n_idle;
      n_idle = $urandom_range(1, 15);
      for (int unsigned j = 0; j < n_idle; j++) begin
        idle_cycle(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5000),
                   ($urandom_range(0, 3) == 0));
      end
      run_return($urandom_range(0, 60) * 50 + (($urandom_range(0, 4) == 0) ? 7 : 0),
                 1'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
